// File: rtl/odo_pkg.sv
// Shared types and helpers for the Odo round sequencer: datapath widths,
// controller states and the round-key schedule step.
package odo_pkg;

    localparam int ODO_STATE_W = 640;
    localparam int ODO_WORDS   = 10;
    localparam int ODO_KEY_W   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } odo_fsm_t;

    // Next round key: rotate left by one, then fold in the low byte of the round number.
    function automatic logic [ODO_KEY_W-1:0] odo_rk_next(
        input logic [ODO_KEY_W-1:0] rk,
        input logic [7:0]           rnd
    );
        return {rk[ODO_KEY_W-2:0], rk[ODO_KEY_W-1]} ^ {2'b00, rnd};
    endfunction

endpackage

// File: rtl/odo_apply_round_key.sv
// XORs key bit i into bit 0 of state word i; every other state bit passes through.
module odo_apply_round_key
    import odo_pkg::*;
(
    input  logic [ODO_KEY_W-1:0]   rk,
    input  logic [ODO_STATE_W-1:0] state_in,
    output logic [ODO_STATE_W-1:0] state_out
);

    generate
        for (genvar gi = 0; gi < ODO_WORDS; gi++) begin : g_word
            assign state_out[64*gi]             = state_in[64*gi] ^ rk[gi];
            assign state_out[64*gi+63:64*gi+1]  = state_in[64*gi+63:64*gi+1];
        end
    endgenerate

endmodule

// File: rtl/odo_rk_sched.sv
// Round-key and round-counter registers: loaded with a job's key seed, stepped
// once per round, and flagging the final round of the job.
module odo_rk_sched
    import odo_pkg::*;
#(
    parameter int ROUNDS = 84,
    parameter int RC_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 clr,
    input  logic [ODO_KEY_W-1:0] key,
    output logic [ODO_KEY_W-1:0] rk,
    output logic [RC_W-1:0]      rnd,
    output logic                 last
);

    logic [ODO_KEY_W-1:0] rk_q;
    logic [RC_W-1:0]      rnd_q;
    logic [7:0]           rnd8;

    // The key schedule only ever sees the low byte of the round number.
    generate
        if (RC_W >= 8) begin : g_trunc
            assign rnd8 = rnd_q[7:0];
        end else begin : g_zext
            assign rnd8 = {{(8-RC_W){1'b0}}, rnd_q};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_q  <= '0;
            rnd_q <= '0;
        end else if (load) begin
            rk_q  <= key;
            rnd_q <= '0;
        end else if (step) begin
            rk_q  <= odo_rk_next(rk_q, rnd8);
            rnd_q <= rnd_q + 1'b1;
        end else if (clr) begin
            rnd_q <= '0;
        end
    end

    assign rk   = rk_q;
    assign rnd  = rnd_q;
    assign last = (rnd_q == RC_W'(ROUNDS - 1));

endmodule

// File: rtl/odo_round_sequencer.sv
// Iterative Odo round controller: latches one job, drives the external mix core
// for ROUNDS cycles while keying each round, then holds the result for handoff.
module odo_round_sequencer
    import odo_pkg::*;
#(
    parameter int ROUNDS = 84,
    parameter int RC_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ODO_STATE_W-1:0] in_state,
    input  logic [ODO_KEY_W-1:0]   in_key,
    output logic [ODO_STATE_W-1:0] mix_in,
    input  logic [ODO_STATE_W-1:0] mix_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ODO_STATE_W-1:0] out_state,
    output logic                   busy,
    output logic [RC_W-1:0]        round_idx
);

    odo_fsm_t               fsm_q;
    logic [ODO_STATE_W-1:0] state_q;
    logic [ODO_STATE_W-1:0] keyed;
    logic [ODO_KEY_W-1:0]   rk;
    logic [RC_W-1:0]        rnd;
    logic                   last;
    logic                   load;
    logic                   step;
    logic                   clr;

    assign load = (fsm_q == IDLE) && in_valid;
    assign step = (fsm_q == RUN);
    assign clr  = (fsm_q == DONE) && out_valid && out_ready;

    odo_rk_sched #(
        .ROUNDS (ROUNDS),
        .RC_W   (RC_W)
    ) u_sched (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .clr  (clr),
        .key  (in_key),
        .rk   (rk),
        .rnd  (rnd),
        .last (last)
    );

    odo_apply_round_key u_ark (
        .rk        (rk),
        .state_in  (mix_out),
        .state_out (keyed)
    );

    // DONE spends its first cycle with out_valid low so the result appears
    // ROUNDS+1 edges after the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= in_state;
                        busy    <= 1'b1;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    state_q <= keyed;
                    if (last) begin
                        busy  <= 1'b0;
                        fsm_q <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm_q     <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm_q == IDLE) && !rst;
    assign mix_in    = state_q;
    assign out_state = state_q;
    assign round_idx = busy ? rnd : '0;

endmodule

// File: tb/tb_odo_round_sequencer.sv
// Randomized bench for odo_round_sequencer: a round-by-round reference model plus
// a cycle timeline drive a per-cycle compare; small instances pin literal results.
module tb_odo_round_sequencer;

    localparam int R84 = 84;
    localparam logic [639:0] MIXC = {10{64'hA5A5_0F0F_1234_5678}};
    localparam logic [639:0] PIN1 = {10{64'h0000_0000_0000_0001}};
    localparam logic [639:0] PIN2 = {512'h0, 64'h1, 64'h1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // main instance, ROUNDS=84, bench-provided mix core
    logic         iv, ir, ov, ordy, bsy;
    logic [639:0] ist, mi, mo, ost;
    logic [9:0]   ik;
    logic [7:0]   ridx;
    logic         mix_mode;

    // pin instances, ROUNDS=1 and ROUNDS=2, loopback mix
    logic         iv1, ir1, ov1, or1, bsy1;
    logic [639:0] ist1, mi1, ost1;
    logic [9:0]   ik1;
    logic [7:0]   ridx1;
    logic         iv2, ir2, ov2, or2, bsy2;
    logic [639:0] ist2, mi2, ost2;
    logic [9:0]   ik2;
    logic [7:0]   ridx2;

    assign mo = mix_mode ? ({mi[638:0], mi[639]} ^ MIXC) : mi;

    odo_round_sequencer #(.ROUNDS(R84), .RC_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_state(ist), .in_key(ik),
        .mix_in(mi), .mix_out(mo), .out_valid(ov), .out_ready(ordy), .out_state(ost),
        .busy(bsy), .round_idx(ridx));

    odo_round_sequencer #(.ROUNDS(1), .RC_W(8)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_state(ist1), .in_key(ik1),
        .mix_in(mi1), .mix_out(mi1), .out_valid(ov1), .out_ready(or1), .out_state(ost1),
        .busy(bsy1), .round_idx(ridx1));

    odo_round_sequencer #(.ROUNDS(2), .RC_W(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_state(ist2), .in_key(ik2),
        .mix_in(mi2), .mix_out(mi2), .out_valid(ov2), .out_ready(or2), .out_state(ost2),
        .busy(bsy2), .round_idx(ridx2));

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each round mixes, then flips bit 0 of word w when key bit w is set,
    // then advances the key as rotl1(key) xor (round mod 256).
    function automatic logic [639:0] model(input logic [639:0] s0, input logic [9:0] key,
                                           input int rounds, input bit scramble_mix);
        logic [639:0] s;
        int rk;
        s  = s0;
        rk = int'(key);
        for (int r = 0; r < rounds; r++) begin
            if (scramble_mix) s = ((s << 1) | (s >> 639)) ^ MIXC;
            for (int w = 0; w < 10; w++)
                if (((rk >> w) & 1) == 1) s[64*w] = ~s[64*w];
            rk = (((rk << 1) | (rk >> 9)) & 'h3FF) ^ (r % 256);
        end
        return s;
    endfunction

    function automatic logic [639:0] rand640();
        logic [639:0] v;
        for (int i = 0; i < 20; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Timeline of the main instance: m_k counts edges since the accept edge.
    logic         m_active = 1'b0;
    int           m_k = 0;
    logic [639:0] m_exp = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
        end else if (!m_active) begin
            if (iv) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_exp    <= model(ist, ik, R84, mix_mode);
            end
        end else if (m_k > R84 && ordy) begin
            m_active <= 1'b0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        logic e_ir, e_b, e_ov;
        logic [7:0] e_idx;
        e_ir = 1'b0; e_b = 1'b0; e_ov = 1'b0; e_idx = 8'd0;
        if (!rst) begin
            if (!m_active) begin
                e_ir = 1'b1;
            end else if (m_k < R84) begin
                e_b   = 1'b1;
                e_idx = 8'(m_k);
            end else if (m_k > R84) begin
                e_ov = 1'b1;
            end
        end
        chk("in_ready", 640'(ir), 640'(e_ir));
        chk("busy", 640'(bsy), 640'(e_b));
        chk("round_idx", 640'(ridx), 640'(e_idx));
        chk("out_valid", 640'(ov), 640'(e_ov));
        if (e_ov) chk("out_state", ost, m_exp);
    end

    // Runs one job on the main instance; entered and left on a falling edge with it idle.
    task automatic do_job(input logic [639:0] s, input logic [9:0] k, input int hold,
                          input bit scramble, input bit chain,
                          input logic [639:0] next_s, input logic [9:0] next_k);
        int n, bc;
        logic [639:0] snap;
        ist = s; ik = k; iv = 1'b1; ordy = 1'b0;
        @(negedge clk);
        iv = scramble;
        n = 0; bc = 0;
        while (!(m_active && m_k > R84) && n < 400) begin
            if (bsy) bc++;
            if (scramble) begin ist = rand640(); ik = 10'($urandom); end
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= 400) begin
            n_fail++;
            $display("FAIL job_timeout: waited %0d cycles for out_valid", n);
        end
        chk("busy_cycles", 640'(bc), 640'(R84));
        iv = 1'b0;
        snap = ost;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_stable", ost, snap);
            chk("hold_in_ready", 640'(ir), 640'(0));
        end
        ordy = 1'b1;
        if (chain) begin iv = 1'b1; ist = next_s; ik = next_k; end
        @(negedge clk);
        ordy = 1'b0;
    endtask

    initial begin
        int lat, n;
        logic [639:0] s_next;
        logic [9:0]   k_next;
        iv = 0; ist = '0; ik = '0; ordy = 0; mix_mode = 0;
        iv1 = 0; ist1 = '0; ik1 = '0; or1 = 0;
        iv2 = 0; ist2 = '0; ik2 = '0; or2 = 0;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_in_ready", 640'(ir), 640'(0));
        chk("rst_out_valid", 640'(ov), 640'(0));
        chk("rst_busy", 640'(bsy), 640'(0));
        chk("rst_round_idx", 640'(ridx), 640'(0));
        chk("rst_out_state", ost, '0);
        chk("rst_mix_in", mi, '0);
        rst = 1'b0;
        #1 chk("release_in_ready", 640'(ir), 640'(1));

        chk("model_pin1", model('0, 10'h3FF, 1, 1'b0), PIN1);
        chk("model_pin2", model('0, 10'h001, 2, 1'b0), PIN2);

        // ROUNDS=1 pin
        @(negedge clk);
        iv1 = 1; ist1 = '0; ik1 = 10'h3FF;
        @(posedge clk); #1 iv1 = 0; lat = 0;
        while (!ov1 && lat < 20) begin @(posedge clk); #1 lat++; end
        chk("r1_latency", 640'(lat), 640'(2));
        chk("r1_state", ost1, PIN1);
        or1 = 1; @(posedge clk); #1 or1 = 0;
        chk("r1_released", 640'(ov1), 640'(0));

        // ROUNDS=2 pin
        iv2 = 1; ist2 = '0; ik2 = 10'h001;
        @(posedge clk); #1 iv2 = 0; lat = 0;
        while (!ov2 && lat < 20) begin @(posedge clk); #1 lat++; end
        chk("r2_latency", 640'(lat), 640'(3));
        chk("r2_state", ost2, PIN2);
        or2 = 1; @(posedge clk); #1 or2 = 0;
        @(negedge clk);

        // loopback, zero key, random state
        mix_mode = 0;
        do_job(rand640(), 10'h000, 0, 1'b0, 1'b0, '0, '0);

        // scrambling mix core, random jobs with backpressure, stray input traffic, chaining
        mix_mode = 1;
        s_next = rand640(); k_next = 10'($urandom);
        for (int j = 0; j < 5; j++) begin
            logic [639:0] s_cur;
            logic [9:0]   k_cur;
            s_cur = s_next; k_cur = k_next;
            s_next = rand640(); k_next = 10'($urandom);
            do_job(s_cur, k_cur, (j == 1) ? 10 : int'($urandom_range(0, 3)),
                   j == 2, j == 3, s_next, k_next);
        end

        // reset in the middle of RUN
        ist = rand640(); ik = 10'($urandom); iv = 1;
        @(negedge clk); iv = 0; n = 0;
        while (m_k != 40 && n < 100) begin @(negedge clk); n++; end
        chk("ridx_before_rst", 640'(ridx), 640'(40));
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("arst_busy", 640'(bsy), 640'(0));
        chk("arst_round_idx", 640'(ridx), 640'(0));
        chk("arst_out_valid", 640'(ov), 640'(0));
        chk("arst_out_state", ost, '0);
        chk("arst_in_ready", 640'(ir), 640'(0));
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        do_job(rand640(), 10'($urandom), 2, 1'b0, 1'b0, '0, '0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
        $fatal(1);
    end

endmodule
